// File: rtl/rgb_preset_fader.sv
// rgb_preset_fader: DEPTH colour presets of N_CH x W bits with masked writes,
// driving a registered colour that jumps or ramps one LSB per tick to a preset.
module rgb_preset_fader #(
  parameter int W     = 8,
  parameter int N_CH  = 3,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [N_CH-1:0]     wr_ch_mask,
  input  logic [N_CH*W-1:0]   wr_data,
  input  logic                load,
  input  logic [AW-1:0]       load_addr,
  input  logic                fade_mode,
  input  logic [15:0]         step_div,
  output logic [N_CH*W-1:0]   color_out,
  output logic                busy,
  output logic                done
);

  typedef enum logic {
    IDLE,
    FADE
  } state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t              state_q;
  state_t              state_d;
  logic [N_CH*W-1:0]   mem [DEPTH];
  logic [N_CH*W-1:0]   tgt_q;
  logic [N_CH*W-1:0]   tgt_d;
  logic [N_CH*W-1:0]   color_d;
  logic [N_CH*W-1:0]   bypass;
  logic [N_CH*W-1:0]   stepped;
  logic [15:0]         div_q;
  logic [15:0]         div_d;
  logic [15:0]         tick_q;
  logic [15:0]         tick_d;
  logic                done_d;

  // Preset storage, each channel gated by its mask bit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        mem[s] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_ch_mask[i]) begin
          mem[wr_addr][i*W +: W] <= wr_data[i*W +: W];
        end
      end
    end
  end

  // Same-edge write bypass for the load target and one-LSB ramp step
  always_comb begin
    bypass  = mem[load_addr];
    stepped = color_out;
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en && (wr_addr == load_addr) && wr_ch_mask[i]) begin
        bypass[i*W +: W] = wr_data[i*W +: W];
      end
      if (color_out[i*W +: W] < tgt_q[i*W +: W]) begin
        stepped[i*W +: W] = color_out[i*W +: W] + ONE;
      end else if (color_out[i*W +: W] > tgt_q[i*W +: W]) begin
        stepped[i*W +: W] = color_out[i*W +: W] - ONE;
      end
    end
  end

  // Next-state: load acceptance in IDLE, prescaled stepping in FADE
  always_comb begin
    state_d = state_q;
    color_d = color_out;
    tgt_d   = tgt_q;
    div_d   = div_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          if (!fade_mode || (bypass == color_out)) begin
            color_d = bypass;
            done_d  = 1'b1;
          end else begin
            state_d = FADE;
            tgt_d   = bypass;
            div_d   = step_div;
            tick_d  = '0;
          end
        end
      end
      FADE: begin
        if (tick_q == div_q) begin
          tick_d  = '0;
          color_d = stepped;
          if (stepped == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      color_out <= '0;
      tgt_q     <= '0;
      div_q     <= '0;
      tick_q    <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      color_out <= color_d;
      tgt_q     <= tgt_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      done      <= done_d;
    end
  end

  assign busy = (state_q == FADE);

endmodule

// File: tb/tb_rgb_preset_fader.sv
// tb_rgb_preset_fader: directed vectors plus a closed-form ramp model
// compared against the DUT on every falling edge.
module tb_rgb_preset_fader;

  localparam int W     = 8;
  localparam int N_CH  = 3;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [N_CH-1:0]   wr_ch_mask;
  logic [N_CH*W-1:0] wr_data;
  logic              load;
  logic [AW-1:0]     load_addr;
  logic              fade_mode;
  logic [15:0]       step_div;
  logic [N_CH*W-1:0] color_out;
  logic              busy;
  logic              done;

  rgb_preset_fader #(
    .W(W), .N_CH(N_CH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_ch_mask(wr_ch_mask), .wr_data(wr_data),
    .load(load), .load_addr(load_addr),
    .fade_mode(fade_mode), .step_div(step_div),
    .color_out(color_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: ramp position is a closed-form function of
  // the cycles elapsed since acceptance.
  int  m_mem [DEPTH][N_CH];
  int  m_col [N_CH];
  int  m_start [N_CH];
  int  m_tgt [N_CH];
  bit  m_active = 0;
  bit  m_done = 0;
  bit  armed = 0;
  int  m_k, m_len, m_div;

  always @(posedge clk) begin
    int t [N_CH];
    int md, d, a, s;
    bit same;
    m_done = 0;
    if (rst) begin
      for (int j = 0; j < DEPTH; j++)
        for (int i = 0; i < N_CH; i++) m_mem[j][i] = 0;
      for (int i = 0; i < N_CH; i++) m_col[i] = 0;
      m_active = 0;
      armed = 1;
    end else begin
      if (m_active) begin
        m_k++;
        for (int i = 0; i < N_CH; i++) begin
          d = m_tgt[i] - m_start[i];
          a = (d < 0) ? -d : d;
          s = m_k / (m_div + 1);
          if (s > a) s = a;
          m_col[i] = (d < 0) ? m_start[i] - s : m_start[i] + s;
        end
        if (m_k == m_len) begin
          m_active = 0;
          m_done = 1;
        end
      end else if (load) begin
        same = 1;
        md = 0;
        for (int i = 0; i < N_CH; i++) begin
          if (wr_en && wr_addr == load_addr && wr_ch_mask[i])
            t[i] = int'(wr_data[i*W +: W]);
          else
            t[i] = m_mem[load_addr][i];
          if (t[i] != m_col[i]) same = 0;
          d = t[i] - m_col[i];
          a = (d < 0) ? -d : d;
          if (a > md) md = a;
        end
        if (!fade_mode || same) begin
          for (int i = 0; i < N_CH; i++) m_col[i] = t[i];
          m_done = 1;
        end else begin
          m_active = 1;
          m_k = 0;
          m_div = int'(step_div);
          m_len = (m_div + 1) * md;
          for (int i = 0; i < N_CH; i++) begin
            m_start[i] = m_col[i];
            m_tgt[i] = t[i];
          end
        end
      end
      if (wr_en)
        for (int i = 0; i < N_CH; i++)
          if (wr_ch_mask[i]) m_mem[wr_addr][i] = int'(wr_data[i*W +: W]);
    end
  end

  function automatic logic [N_CH*W-1:0] m_pack();
    logic [N_CH*W-1:0] e;
    for (int i = 0; i < N_CH; i++) e[i*W +: W] = m_col[i][W-1:0];
    return e;
  endfunction

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("model_color", color_out, m_pack());
      chk("model_busy", busy, m_active);
      chk("model_done", done, m_done);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [N_CH-1:0] m,
                    input logic [N_CH*W-1:0] dv);
    wr_en = 1; wr_addr = a; wr_ch_mask = m; wr_data = dv;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic ld(input logic [AW-1:0] a, input logic f,
                    input logic [15:0] dv);
    load = 1; load_addr = a; fade_mode = f; step_div = dv;
    @(negedge clk);
    load = 0;
  endtask

  int cnt;
  bit wrapped;
  logic [W-1:0] prev;

  initial begin
    rst = 1; wr_en = 0; wr_addr = 0; wr_ch_mask = 0; wr_data = 0;
    load = 0; load_addr = 0; fade_mode = 0; step_div = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_color", color_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    wr(1, 3'b111, 24'h1E140A);
    ld(1, 0, 0);
    chk("jump_color", color_out, 24'h1E140A);
    chk("jump_done", done, 1);
    chk("jump_busy", busy, 0);
    @(negedge clk);
    chk("jump_done_once", done, 0);

    wr(2, 3'b010, 24'hFFFFFF);
    ld(2, 0, 0);
    chk("mask_color", color_out, 24'h00FF00);

    ld(0, 0, 0);
    chk("zero_color", color_out, 0);
    wr(3, 3'b111, 24'h000004);
    ld(3, 1, 16'd2);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (!busy) break;
      cnt++;
      if (cnt == 4) begin
        load = 1; load_addr = 1; fade_mode = 0;
        wr_en = 1; wr_addr = 3; wr_ch_mask = 3'b111; wr_data = 24'h000009;
      end else begin
        load = 0; wr_en = 0;
      end
      if (cnt == 7) chk("fade_mid", color_out, 24'h000002);
      @(negedge clk);
    end
    load = 0; wr_en = 0;
    chk("fade_busy_len", cnt, 12);
    chk("fade_end_color", color_out, 24'h000004);
    chk("fade_end_done", done, 1);

    wr(0, 3'b111, 24'h0000FF);
    ld(0, 0, 0);
    chk("ff_color", color_out, 24'h0000FF);
    wr(1, 3'b111, 24'h000000);
    ld(1, 1, 16'd0);
    cnt = 0; wrapped = 0; prev = 8'hFF;
    for (int c = 0; c < 400; c++) begin
      if (!busy) break;
      cnt++;
      if (color_out[7:0] > prev) wrapped = 1;
      prev = color_out[7:0];
      @(negedge clk);
    end
    chk("down_len", cnt, 255);
    chk("down_nowrap", wrapped, 0);
    chk("down_color", color_out, 0);
    chk("down_done", done, 1);

    ld(0, 0, 0);
    ld(1, 1, 16'd0);
    repeat (100) @(negedge clk);
    chk("rerun_mid", color_out, 24'h00009B);
    chk("rerun_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_color", color_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    ld(0, 0, 0);
    chk("clr0_color", color_out, 0);
    ld(3, 0, 0);
    chk("clr3_color", color_out, 0);

    wr(1, 3'b111, 24'h060606);
    wr(2, 3'b111, 24'h112233);
    wr_en = 1; wr_addr = 0; wr_ch_mask = 3'b111; wr_data = 24'h050505;
    load = 1; load_addr = 0; fade_mode = 0;
    @(negedge clk);
    wr_en = 0; load = 0;
    chk("bypass_color", color_out, 24'h050505);
    chk("bypass_done", done, 1);
    ld(1, 1, 16'd0);
    chk("ondone_busy", busy, 1);
    chk("ondone_color", color_out, 24'h050505);
    @(negedge clk);
    chk("short_color", color_out, 24'h060606);
    chk("short_done", done, 1);
    chk("short_busy", busy, 0);
    ld(1, 1, 16'd5);
    chk("equal_done", done, 1);
    chk("equal_busy", busy, 0);

    wr_en = 1; wr_addr = 2; wr_ch_mask = 3'b010; wr_data = 24'hAAAAAA;
    load = 1; load_addr = 2; fade_mode = 0;
    @(negedge clk);
    wr_en = 0; load = 0;
    chk("partbypass_color", color_out, 24'h11AA33);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_preset_fader.md
Name: rgb_preset_fader

Overview:
- Parametrised successor of the three-channel colour register unit.
- Holds DEPTH colour presets of N_CH channels, each W bits wide, with per-channel write masking.
- Drives a registered colour output that either jumps to a selected preset or ramps toward it one LSB per channel per prescaled tick.
- Sits between the input/control logic and the PWM drivers.

Parameters:
- W, 8, bits per colour channel.
- N_CH, 3, number of channels (R, G, B by default).
- DEPTH, 4, number of preset slots (power of two, ≥2).
- AW, $clog2(DEPTH), preset address width (derived; do not override).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  preset write strobe.
- wr_addr  in  AW  preset slot to write.
- wr_ch_mask  in  N_CH  per-channel write enable; bit i gates channel i.
- wr_data  in  N_CH*W  write data; channel i is bits [i*W +: W].
- load  in  1  request transition to preset load_addr.
- load_addr  in  AW  preset slot to transition to.
- fade_mode  in  1  0 = immediate jump, 1 = ramp; sampled with load.
- step_div  in  16  ramp prescaler; one step every step_div+1 cycles; sampled with load.
- color_out  out  N_CH*W  current colour, registered, same channel packing.
- busy  out  1  high while in FADE.
- done  out  1  one-cycle pulse when a transition completes.

Behaviour:
- Reset (rst=1 at edge):
  - All preset entries cleared to 0.
  - color_out=0, busy=0, done=0, state IDLE, tick counter 0.
  - Overrides any write, load or fade in progress.
- Preset write:
  - At an edge with wr_en=1, mem[wr_addr][i] <= wr_data slice i for every i with wr_ch_mask[i]=1.
  - Unmasked channels keep their value.
  - Writes are accepted in any state.
- Load acceptance:
  - Accepted only in IDLE; load while busy=1 is ignored, with no queueing.
  - The target is the preset content after any same-edge write to load_addr (write-through bypass, per channel by mask).
  - fade_mode and step_div are latched at acceptance.
  - The target is latched in a private register; later writes to that slot do not affect an active fade.
- Immediate (fade_mode=0), or fade target already equal to color_out:
  - color_out <= target on the accepting edge.
  - done=1 for the following cycle.
  - State stays IDLE; busy stays 0.
- FADE (fade_mode=1, target differs from color_out):
  - Accepting edge: state FADE, busy=1, tick=0.
  - Each cycle in FADE: if tick==step_div_latched, tick<=0 and every channel with color_out≠target moves exactly 1 LSB toward target (unsigned, no wrap; equal channels hold). Otherwise tick<=tick+1.
  - On the step edge at which all channels reach target: state IDLE, busy<=0, and done=1 for the next cycle.
  - Ramp length equals max over channels of |target−start| steps, i.e. (step_div+1)·maxdiff cycles from the accepting edge.
- Boundaries:
  - step_div=0 means one step per cycle.
  - Channel values 0 and 2^W−1 never overflow or underflow.
  - done never coincides with busy=1.
  - A load arriving in the same cycle that done is high is accepted normally.

Test Plan:
- Reset, then write slot 1 = {B=30,G=20,R=10} with mask 3'b111; load slot 1, fade_mode=0 -> color_out=0x1E140A one cycle after load, done pulse 1 cycle, busy stays 0.
- Write slot 2 mask 3'b010 data 0xFFFFFF over slot 2 = 0 -> slot 2 reads {0,255,0}; load slot 2 immediate -> color_out=0x00FF00.
- From 0x000000, load slot 3={0,0,4} with fade_mode=1, step_div=2 -> R steps 1,2,3,4 every 3 cycles, busy high for 12 cycles, then a single done pulse.
- During that fade, pulse load to slot 1 and write slot 3 = 0x000009 -> load ignored, fade still ends at R=4.
- Fade from 0x0000FF to 0x000000 with step_div=0 -> R decrements 255 to 0 in 255 cycles, never wraps; then assert rst mid-way in a repeat run -> color_out=0, busy=0, all presets 0 next cycle.
- Same-edge wr_en to slot 0 (data 0x050505) and load slot 0 immediate -> color_out=0x050505.
